// File: rtl/alu_commit_arb_pkg.sv
// Types local to the ALU commit arbiter.
package alu_commit_arb_pkg;
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } wb_state_e;
endpackage

// File: rtl/core_config_pkg.sv
// Core-wide configuration constants and the commit entry layout shared by
// the writeback-side blocks.
package core_config_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_COUNT  = 4;
  // Wide enough for the largest supported ALU count (8).
  localparam int SRC_W      = 3;

  typedef struct packed {
    logic [XLEN-1:0]       data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  error;
    logic [SRC_W-1:0]      src;
  } commit_entry_t;
endpackage

// File: rtl/alu_commit_arb_if.sv
// Commit-side bundle between the ALUs, the arbiter and the register-file/
// exception consumer.
interface alu_commit_arb_if #(
  parameter int N_ALU      = 4,
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  import alu_commit_arb_pkg::*;
  localparam int IDX_W = (N_ALU > 1) ? $clog2(N_ALU) : 1;

  // Handshakes: an ALU holds alu_valid (with res/rd/error stable) until it sees
  // alu_clear; a writeback entry transfers on any cycle with wb_valid && wb_ready,
  // and wb_ready may be asserted independently of wb_valid.
  logic [N_ALU-1:0]            alu_valid;
  logic [N_ALU*XLEN-1:0]       alu_res;
  logic [N_ALU*REG_ADDR_W-1:0] alu_rd;
  logic [N_ALU-1:0]            alu_error;
  logic [N_ALU-1:0]            alu_clear;
  logic                        wb_valid;
  logic                        wb_we;
  logic [REG_ADDR_W-1:0]       wb_rd;
  logic [XLEN-1:0]             wb_data;
  logic                        wb_ready;
  logic                        exc_valid;
  logic [IDX_W-1:0]            exc_src;
  logic                        flush;
  wb_state_e                   state_dbg;
  logic [IDX_W-1:0]            ptr_dbg;

  modport master (
    output alu_valid, alu_res, alu_rd, alu_error, wb_ready, flush,
    input  alu_clear, wb_valid, wb_we, wb_rd, wb_data, exc_valid, exc_src,
           state_dbg, ptr_dbg
  );

  modport slave (
    input  alu_valid, alu_res, alu_rd, alu_error, wb_ready, flush,
    output alu_clear, wb_valid, wb_we, wb_rd, wb_data, exc_valid, exc_src,
           state_dbg, ptr_dbg
  );
endinterface

// File: rtl/alu_commit_arb_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);
  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        grant                        = '0;
        grant[(int'(ptr) + k) % N]   = 1'b1;
        grant_idx                    = IDX_W'((int'(ptr) + k) % N);
        any                          = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_commit_arb.sv
// Shares the single register-file writeback port between N_ALU holding ALUs
// through a one-entry output register refilled in the cycle it drains.
module alu_commit_arb
  import alu_commit_arb_pkg::*;
#(
  parameter  int N_ALU      = core_config_pkg::ALU_COUNT,
  parameter  int XLEN       = core_config_pkg::XLEN,
  parameter  int REG_ADDR_W = core_config_pkg::REG_ADDR_W,
  localparam int IDX_W      = (N_ALU > 1) ? $clog2(N_ALU) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_commit_arb_if.slave  bus
);
  wb_state_e             state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [XLEN-1:0]       data_q, data_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  err_q, err_d;
  logic [IDX_W-1:0]      src_q, src_d;

  logic [N_ALU-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             any_req;
  logic             can_accept;
  logic             grant_en;

  rr_arbiter #(.N(N_ALU)) u_rr (
    .req       (bus.alu_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_req)
  );

  assign can_accept = (state_q == ST_EMPTY) || bus.wb_ready;
  assign grant_en   = can_accept && !bus.flush && any_req;

  // Flush releases every holding ALU; otherwise only the granted one.
  always_comb begin
    bus.alu_clear = '0;
    if (bus.flush)     bus.alu_clear = bus.alu_valid;
    else if (grant_en) bus.alu_clear = grant;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    rd_d    = rd_q;
    err_d   = err_q;
    src_d   = src_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else if (grant_en) begin
      state_d = ST_FULL;
      data_d  = bus.alu_res[int'(grant_idx)*XLEN +: XLEN];
      rd_d    = bus.alu_rd[int'(grant_idx)*REG_ADDR_W +: REG_ADDR_W];
      err_d   = bus.alu_error[grant_idx];
      src_d   = grant_idx;
      ptr_d   = (grant_idx == IDX_W'(N_ALU - 1)) ? '0 : grant_idx + 1'b1;
    end else if ((state_q == ST_FULL) && bus.wb_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      src_q   <= src_d;
    end
  end

  // Writes to x0 and error commits still handshake but never write the file.
  assign bus.wb_valid  = (state_q == ST_FULL);
  assign bus.wb_we     = (state_q == ST_FULL) && !err_q && (rd_q != '0);
  assign bus.wb_rd     = rd_q;
  assign bus.wb_data   = data_q;
  assign bus.exc_valid = (state_q == ST_FULL) && err_q;
  assign bus.exc_src   = src_q;
  assign bus.state_dbg = state_q;
  assign bus.ptr_dbg   = ptr_q;
endmodule

// File: tb/tb_alu_commit_arb.sv
// Randomized bench for alu_commit_arb against a queue-based commit model.
module tb_alu_commit_arb;
  localparam int N   = 4;
  localparam int XL  = 32;
  localparam int RW  = 5;
  localparam int IW  = 2;
  localparam int E_W = IW + 1 + RW + XL;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_commit_arb_if #(.N_ALU(N), .XLEN(XL), .REG_ADDR_W(RW)) bus ();

  alu_commit_arb #(.N_ALU(N), .XLEN(XL), .REG_ADDR_W(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ALU-side state held by the bench
  logic          hold  [N];
  logic [XL-1:0] a_res [N];
  logic [RW-1:0] a_rd  [N];
  logic          a_err [N];

  // scoreboard: the one-entry output register is modelled as a queue
  logic [E_W-1:0] exp_q[$];
  logic [E_W-1:0] last_e;
  int             m_ptr;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [E_W-1:0] mk_entry(input int i);
    return {IW'(i), a_err[i], a_rd[i], a_res[i]};
  endfunction

  task automatic load_alu(input int i, input logic [XL-1:0] res, input logic [RW-1:0] rd, input logic err);
    hold[i]  = 1'b1;
    a_res[i] = res;
    a_rd[i]  = rd;
    a_err[i] = err;
  endtask

  task automatic drive_inputs(input logic rdy, input logic fl);
    for (int i = 0; i < N; i++) begin
      bus.alu_valid[i]          = hold[i];
      bus.alu_res[i*XL +: XL]   = a_res[i];
      bus.alu_rd[i*RW +: RW]    = a_rd[i];
      bus.alu_error[i]          = hold[i] ? a_err[i] : 1'($urandom_range(0, 1));
    end
    bus.wb_ready = rdy;
    bus.flush    = fl;
  endtask

  task automatic check_outputs();
    logic [E_W-1:0] e;
    logic           full;
    logic           err;
    logic [RW-1:0]  rd;
    full = (exp_q.size() != 0);
    e    = full ? exp_q[0] : last_e;
    err  = e[XL+RW];
    rd   = e[XL+RW-1:XL];
    check_eq("wb_valid",  64'(bus.wb_valid),  64'(full));
    check_eq("wb_data",   64'(bus.wb_data),   64'(e[XL-1:0]));
    check_eq("wb_rd",     64'(bus.wb_rd),     64'(rd));
    check_eq("wb_we",     64'(bus.wb_we),     64'(full && !err && rd != 0));
    check_eq("exc_valid", 64'(bus.exc_valid), 64'(full && err));
    check_eq("exc_src",   64'(bus.exc_src),   64'(e[E_W-1 -: IW]));
    check_eq("ptr",       64'(bus.ptr_dbg),   64'(m_ptr));
  endtask

  // One clock: drive, check the same-cycle clear, advance model, check registers.
  task automatic run_cycle(input logic rdy, input logic fl);
    logic [N-1:0] exp_clear;
    int           g;
    int           best;
    int           d;
    logic         can;
    drive_inputs(rdy, fl);
    @(negedge clk);
    exp_clear = '0;
    g         = -1;
    can       = (exp_q.size() == 0) || rdy;
    if (fl) begin
      for (int i = 0; i < N; i++) exp_clear[i] = hold[i];
    end else if (can) begin
      best = N;
      for (int i = 0; i < N; i++) begin
        d = (i - m_ptr + N) % N;
        if (hold[i] && d < best) begin
          best = d;
          g    = i;
        end
      end
      if (g >= 0) exp_clear[g] = 1'b1;
    end
    check_eq("alu_clear", 64'(bus.alu_clear), 64'(exp_clear));
    if (fl) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
      if (g >= 0) begin
        exp_q.push_back(mk_entry(g));
        last_e = mk_entry(g);
        m_ptr  = (g + 1) % N;
      end
    end
    for (int i = 0; i < N; i++) if (exp_clear[i]) hold[i] = 1'b0;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) hold[i] = 1'b0;
    drive_inputs(1'b0, 1'b0);
    exp_q.delete();
    last_e = '0;
    m_ptr  = 0;
    #1;
    check_outputs();
    check_eq("rst_clear", 64'(bus.alu_clear), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic random_refill();
    for (int i = 0; i < N; i++) begin
      if (!hold[i] && $urandom_range(0, 2) == 0)
        load_alu(i, $urandom, RW'($urandom_range(0, 31)), $urandom_range(0, 7) == 0);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      hold[i] = 1'b0; a_res[i] = '0; a_rd[i] = '0; a_err[i] = 1'b0;
    end
    drive_inputs(1'b0, 1'b0);
    #2;
    do_reset();

    // round-robin with all ALUs continuously valid
    for (int i = 0; i < N; i++) load_alu(i, 32'h1000 + i, RW'(i + 1), 1'b0);
    repeat (5) begin
      run_cycle(1'b1, 1'b0);
      for (int i = 0; i < N; i++)
        if (!hold[i]) load_alu(i, $urandom, RW'($urandom_range(1, 31)), 1'b0);
    end
    repeat (6) run_cycle(1'b1, 1'b0);

    // single ALU
    load_alu(1, 32'hDEADBEEF, 5'd7, 1'b0);
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b0);

    // backpressure
    load_alu(0, 32'h11, 5'd3, 1'b0);
    run_cycle(1'b1, 1'b0);
    load_alu(3, 32'h33, 5'd4, 1'b0);
    repeat (5) run_cycle(1'b0, 1'b0);
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b0);

    // error entry, then x0 destination
    load_alu(2, 32'hBAD, 5'd9, 1'b1);
    run_cycle(1'b1, 1'b0);
    load_alu(1, 32'd5, 5'd0, 1'b0);
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b0);

    // flush while full
    load_alu(0, 32'h77, 5'd2, 1'b0);
    run_cycle(1'b1, 1'b0);
    load_alu(0, 32'hA0, 5'd1, 1'b0);
    load_alu(1, 32'hA1, 5'd2, 1'b0);
    load_alu(2, 32'hA2, 5'd3, 1'b0);
    run_cycle(1'b1, 1'b1);
    run_cycle(1'b0, 1'b0);

    // randomized traffic
    repeat (3000) begin
      random_refill();
      run_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0);
    end

    // reset mid-stream while full
    for (int i = 0; i < N; i++) hold[i] = 1'b0;
    load_alu(1, 32'h5555, 5'd6, 1'b0);
    run_cycle(1'b1, 1'b0);
    #2;
    do_reset();
    load_alu(2, 32'h2222, 5'd12, 1'b0);
    load_alu(3, 32'h3333, 5'd13, 1'b0);
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_commit_arb.md
Name: alu_commit_arb

Overview:
- Commit-side arbiter that shares the single register-file writeback port between N multi-cycle ALUs (alu2/alu3 class units and similar).
- Each ALU holds its result with valid=1 until it receives a clear pulse.
- The arbiter grants one ALU per cycle in round-robin order, captures its result into a one-entry output register and pulses that ALU's clear.
- Sits between the ALU commit interfaces and the register-file/exception logic.

Parameters:
- N_ALU, 4, number of ALU commit interfaces (2..8).
- XLEN, core_config_pkg::XLEN (32), result width.
- REG_ADDR_W, core_config_pkg::REG_ADDR_W (5), destination register index width.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  N_ALU  per-ALU result-held flag.
- alu_res  in  N_ALU*XLEN  packed results; ALU i at [i*XLEN +: XLEN].
- alu_rd  in  N_ALU*REG_ADDR_W  packed destination registers.
- alu_error  in  N_ALU  per-ALU error flag, qualified by alu_valid.
- alu_clear  out  N_ALU  one-hot release pulse to the granted ALU(s).
- wb_valid  out  1  output register holds an entry.
- wb_we  out  1  register-file write enable (wb_valid, no error, rd != 0).
- wb_rd  out  REG_ADDR_W  destination register.
- wb_data  out  XLEN  result data.
- wb_ready  in  1  consumer accepts the entry this cycle.
- exc_valid  out  1  entry is an error commit.
- exc_src  out  $clog2(N_ALU)  index of the ALU that raised the error.
- flush  in  1  pipeline flush; drops the pending entry and releases all holding ALUs.

Behaviour:
- Reset (async, rst_n=0):
  - wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, exc_valid=0, exc_src=0, alu_clear=0.
  - Round-robin pointer=0; state=EMPTY.
- Output state machine, two states:
  - EMPTY: no entry held.
  - FULL: entry held; wb_valid=1.
- can_accept = (state==EMPTY) || wb_ready. The register is refilled in the same cycle it drains, so back-to-back throughput is 1/cycle.
- Grant (combinational): if can_accept && !flush && |alu_valid, select the first i with alu_valid[i]=1, searching from ptr upward with wrap modulo N_ALU.
  - alu_clear[g]=1 in that same cycle.
  - On the next edge: capture alu_res[g], alu_rd[g], alu_error[g] and g; ptr <= (g+1) mod N_ALU; state <= FULL.
- No grant while FULL && !wb_ready. alu_clear stays 0 and the ALUs keep holding.
- FULL && wb_ready && no grant -> EMPTY. wb_data/wb_rd keep their last value; wb_we=0.
- Latency: ALU valid at cycle t with can_accept -> wb_valid at t+1.
- Error entry:
  - exc_valid=1, exc_src=g, wb_we=0; wb_data/wb_rd still carry the captured values.
  - Needs the same wb_ready handshake as a normal entry.
- rd==0: the entry is still committed and handshaken, with wb_we=0 (x0 write suppressed).
- alu_error with alu_valid=0 is ignored.
- Flush (synchronous, highest priority):
  - alu_clear = alu_valid (every holding ALU released) in the flush cycle.
  - state <= EMPTY; no capture that cycle; ptr unchanged.
- Simultaneous wb_ready and flush: flush wins; the entry is discarded. The consumer must ignore wb_ready-accepted data when flush is asserted.
- Fairness: an ALU holding valid is granted within N_ALU accepted commits.
- Mid-operation reset returns to reset values immediately; ALUs are reset by the same rst_n.
- alu_clear must never be asserted to an ALU whose alu_valid=0.

Decomposition:
- core_config_pkg: XLEN and REG_ADDR_W already exist. Add ALU_COUNT (default for N_ALU) and a commit_entry_t struct {data, rd, error, src}.
- One sub-module: rr_arbiter (parameter N; inputs req[N], ptr; outputs grant one-hot, grant_idx, any).
  - Purely combinational, reusable by the issue side.
  - ptr and state registers stay in alu_commit_arb.

Test Plan:
- Single ALU: alu_valid=4'b0010, res=32'hDEADBEEF, rd=5'd7, wb_ready=1 -> alu_clear=4'b0010 in cycle t; at t+1 wb_valid=1, wb_we=1, wb_rd=7, wb_data=DEADBEEF; ptr=2.
- Round-robin: all four ALUs valid continuously, wb_ready=1, ptr=0 -> grants 0,1,2,3,0 on consecutive cycles, one alu_clear bit per cycle.
- Backpressure: entry FULL, wb_ready=0 for 5 cycles with alu_valid=4'b1000 -> alu_clear=0 throughout and wb outputs stable. wb_ready=1 -> ALU3 granted that cycle, its entry visible the next cycle.
- Error/x0: ALU2 valid with error=1, rd=9 -> exc_valid=1, exc_src=2, wb_we=0. ALU1 valid, rd=0, res=5 -> wb_valid=1, wb_we=0.
- Flush: state FULL, alu_valid=4'b0111, flush=1 -> alu_clear=4'b0111; next cycle wb_valid=0, ptr unchanged.
- Reset mid-stream: rst_n low while FULL -> all outputs 0 asynchronously; after release the first grant goes to the lowest valid index from ptr=0.
